// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC/IR fetch stage feeding execute, redirected by resolved branches.
// Optional multi-cycle NOP idling is enabled by defining IFU_NOP_DELAY_EN.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd0
`ifdef IFU_NOP_DELAY_EN
  , parameter logic [3:0] NOP_OPCODE = 4'd0
`endif
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [7:0]  iBranchTarget,
  output logic        oValid,
  output logic [15:0] oPC,
  output logic [3:0]  oOpcode,
  output logic [7:0]  oDst,
  output logic [7:0]  oSrc1,
  output logic [7:0]  oSrc0,
  output logic [15:0] oImm16
);
  typedef enum logic [1:0] {
    FETCH,
    FLUSH
`ifdef IFU_NOP_DELAY_EN
    , DELAY
`endif
  } state_t;
  state_t      r_state, w_state;
  logic [15:0] r_pc, w_pc, r_opc, w_opc;
  logic [27:0] r_ir, w_ir;
  logic        r_valid, w_valid;
  logic        w_fetch;
`ifdef IFU_NOP_DELAY_EN
  logic [23:0] r_cnt, w_cnt;
`endif
  // FLUSH only marks the bubble already emitted by the redirect; it fetches like FETCH
  assign w_fetch = !iStall && (r_state inside {FETCH, FLUSH});
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_ir    = r_ir;
    w_opc   = r_opc;
    w_valid = r_valid;
`ifdef IFU_NOP_DELAY_EN
    w_cnt   = r_cnt;
`endif
    if (iBranchTaken) begin
      w_pc    = {8'd0, iBranchTarget};
      w_valid = 1'b0;
      w_state = FLUSH;
`ifdef IFU_NOP_DELAY_EN
      w_cnt   = 24'd0;
`endif
    end else if (w_fetch) begin
      w_ir    = iInstruction;
      w_opc   = r_pc;
      w_valid = 1'b1;
      w_pc    = r_pc + 16'd1;
      w_state = FETCH;
`ifdef IFU_NOP_DELAY_EN
      if (iInstruction[27:24] == NOP_OPCODE && iInstruction[23:0] != 24'd0) begin
        w_state = DELAY;
        w_cnt   = iInstruction[23:0];
      end
`endif
    end
`ifdef IFU_NOP_DELAY_EN
    else if (!iStall) begin
      w_valid = 1'b0;
      w_cnt   = r_cnt - 24'd1;
      w_state = (r_cnt == 24'd1) ? FETCH : DELAY;
    end
`endif
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 28'd0;
      r_opc   <= 16'd0;
      r_valid <= 1'b0;
`ifdef IFU_NOP_DELAY_EN
      r_cnt   <= 24'd0;
`endif
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_ir    <= w_ir;
      r_opc   <= w_opc;
      r_valid <= w_valid;
`ifdef IFU_NOP_DELAY_EN
      r_cnt   <= w_cnt;
`endif
    end
  end
  assign oAddress = r_pc;
  assign oValid   = r_valid;
  assign oPC      = r_opc;
  assign oOpcode  = r_ir[27:24];
  assign oDst     = r_ir[23:16];
  assign oSrc1    = r_ir[15:8];
  assign oSrc0    = r_ir[7:0];
  assign oImm16   = r_ir[15:0];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for the fetch unit; a second instance starts at 16'hFFFF for wrap.
module tb_instruction_fetch_unit;
`ifdef IFU_NOP_DELAY_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [7:0]  iBranchTarget = 8'd0;
  logic [15:0] oAddress, oPC, oImm16;
  logic [27:0] iInstruction;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDst, oSrc1, oSrc0;
  logic [15:0] w_addr2, w_pc2, w_imm2;
  logic [27:0] w_instr2;
  logic        w_valid2;
  logic [3:0]  w_op2;
  logic [7:0]  w_dst2, w_src12, w_src02;
  logic [27:0] mem [256];
  typedef struct {
    logic [15:0] pc;
    logic [27:0] ir;
    int          gap;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int tests = 0, fails = 0, idle = 0, wi = 0;
  logic stall_s = 1'b0, reset_s = 1'b0;
  logic [15:0] last_pc = 16'd0;
  logic [27:0] last_ir = 28'd0;

  always #5 Clock = ~Clock;
  assign iInstruction = mem[oAddress[7:0]];
  assign w_instr2 = mem[w_addr2[7:0]];

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(oValid), .oPC(oPC), .oOpcode(oOpcode), .oDst(oDst), .oSrc1(oSrc1),
    .oSrc0(oSrc0), .oImm16(oImm16)
  );
  instruction_fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .Clock(Clock), .Reset(Reset), .oAddress(w_addr2), .iInstruction(w_instr2),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(w_valid2), .oPC(w_pc2), .oOpcode(w_op2), .oDst(w_dst2), .oSrc1(w_src12),
    .oSrc0(w_src02), .oImm16(w_imm2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int delay_of(input logic [27:0] i);
    return (NOP_EN && i[27:24] == 4'd0 && i[23:0] != 24'd0) ? int'(i[23:0]) : 0;
  endfunction

  task automatic push(input logic [15:0] pc, input int gap);
    q.push_back('{pc, mem[pc[7:0]], gap});
  endtask

  task automatic wait_pc(input logic [15:0] pc);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(oValid === 1'b1 && oPC == pc) && n < 10000);
    if (!(oValid === 1'b1 && oPC == pc)) begin
      tests++;
      fails++;
      $display("FAIL wait_pc: oPC %0h never presented, last oPC=%0h", pc, oPC);
    end
  endtask

  task automatic branch(input logic [7:0] t);
    iBranchTaken = 1'b1;
    iBranchTarget = t;
    @(negedge Clock);
    iBranchTaken = 1'b0;
  endtask

  always @(posedge Clock) begin
    stall_s <= iStall;
    reset_s <= Reset;
  end

  // Scoreboard monitor: a fresh output is one that was not held by a stall at the last edge
  always @(negedge Clock) begin
    if (!reset_s) idle = 0;
    else if (oValid === 1'b1 && !stall_s) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected: oPC=%0h presented with nothing expected", oPC);
      end else begin
        mon_e = q.pop_front();
        check("pc", {16'd0, oPC}, {16'd0, mon_e.pc});
        check("fields", {4'd0, oOpcode, oDst, oSrc1, oSrc0}, {4'd0, mon_e.ir});
        check("imm16", {16'd0, oImm16}, {16'd0, mon_e.ir[15:0]});
        check("gap", idle, mon_e.gap);
        last_pc = mon_e.pc;
        last_ir = mon_e.ir;
      end
      idle = 0;
    end else if (oValid === 1'b1) begin
      check("hold_pc", {16'd0, oPC}, {16'd0, last_pc});
      check("hold_fields", {4'd0, oOpcode, oDst, oSrc1, oSrc0}, {4'd0, last_ir});
    end else idle++;
  end

  always @(negedge Clock) begin
    if (reset_s && w_valid2 === 1'b1 && !stall_s && wi < 2) begin
      check("wrap_pc", {16'd0, w_pc2}, (wi == 0) ? 32'h0000FFFF : 32'h0);
      wi++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $finish;
  end

  initial begin
    for (int a = 1; a < 256; a++)
      mem[a] = {4'(a % 15 + 1), 8'(a), 8'(a * 3), 8'(a ^ 8'h5A)};
    mem[0] = 28'h0000FA0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_addr", {16'd0, oAddress}, 32'd0);
    check("reset_valid", {31'd0, oValid}, 32'd0);
    check("reset_opc", {16'd0, oPC}, 32'd0);
    check("reset_opcode", {28'd0, oOpcode}, 32'd0);
    for (int p = 0; p < 12; p++) push(16'(p), (p == 1) ? delay_of(mem[0]) : 0);
    Reset = 1'b1;
    wait_pc(16'd9);
    iStall = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("stall_addr", {16'd0, oAddress}, 32'd10);
    end
    iStall = 1'b0;
    wait_pc(16'd11);
    push(16'd7, 1);
    for (int p = 8; p < 11; p++) push(16'(p), 0);
    branch(8'd7);
    check("flush_valid", {31'd0, oValid}, 32'd0);
    check("redirect_addr", {16'd0, oAddress}, 32'd7);
    wait_pc(16'd10);
    mem[0] = {4'd0, 24'd4};
    push(16'd0, 1);
    push(16'd1, delay_of(mem[0]));
    push(16'd2, 0);
    push(16'd3, 0);
    branch(8'd0);
    wait_pc(16'd3);
    push(16'd40, 2);
    push(16'd41, 0);
    branch(8'd30);
    branch(8'd40);
    wait_pc(16'd41);
    push(16'd0, 1);
    if (!NOP_EN) push(16'd1, 0);
    push(16'd0, 0);
    push(16'd1, delay_of(mem[0]));
    branch(8'd0);
    wait_pc(16'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("midreset_valid", {31'd0, oValid}, 32'd0);
    check("midreset_addr", {16'd0, oAddress}, 32'd0);
    Reset = 1'b1;
    wait_pc(16'd0);
    wait_pc(16'd1);
    iStall = 1'b1;
    repeat (3) @(negedge Clock);
    check("drain", q.size(), 32'd0);
    check("wrap_count", wi, 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
